// File: rtl/stdcore_pkg.sv
// rtl/stdcore_pkg.sv - shared types and helpers for the stdcore arbiter blocks
package stdcore_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int src_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stdcore_rr_pick.sv
// rtl/stdcore_rr_pick.sv - combinational round-robin pick, first request at or above ptr
module stdcore_rr_pick
  import stdcore_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = src_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = SW'(j);
      end
    end
  end

endmodule

// File: rtl/stdcore_vrr_arb.sv
// rtl/stdcore_vrr_arb.sv - packet-locking round-robin arbiter into a one-entry output register
module stdcore_vrr_arb
  import stdcore_pkg::*;
#(
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int SW = src_width(N)
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [N*DW-1:0] p,
  input  logic [N-1:0]    p_val,
  input  logic [N-1:0]    p_last,
  output logic [N-1:0]    p_rdy,
  output logic [DW-1:0]   c,
  output logic            c_val,
  output logic            c_last,
  output logic [SW-1:0]   c_src,
  input  logic            c_rdy
);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lk_idx_q, lk_idx_d;
  logic [DW-1:0] c_q, c_d;
  logic          c_val_q, c_val_d;
  logic          c_last_q, c_last_d;
  logic [SW-1:0] c_src_q, c_src_d;

  logic [N-1:0]  pick_gnt;
  logic [SW-1:0] pick_idx;
  logic          pick_any;

  logic [N-1:0]  gnt;
  logic [SW-1:0] sel_idx;
  logic          space;
  logic          xfer;
  logic          sel_last;

  stdcore_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req (p_val),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A locked packet owns the grant even while its requester idles mid-packet.
  always_comb begin
    gnt     = '0;
    sel_idx = pick_idx;
    if (state_q == LOCK) begin
      sel_idx       = lk_idx_q;
      gnt[lk_idx_q] = 1'b1;
    end else if (pick_any) begin
      gnt = pick_gnt;
    end
    if (arst) gnt = '0;
    space    = ~c_val_q | c_rdy;
    p_rdy    = {N{space}} & gnt;
    xfer     = |(p_rdy & p_val);
    sel_last = p_last[sel_idx];
  end

  always_comb begin
    state_d  = state_q;
    lk_idx_d = lk_idx_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (xfer && !sel_last) begin
          state_d  = LOCK;
          lk_idx_d = sel_idx;
        end
      end
      LOCK: begin
        if (xfer && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer && sel_last) begin
      ptr_d = (int'(sel_idx) >= N - 1) ? '0 : sel_idx + SW'(1);
    end
  end

  always_comb begin
    c_d      = c_q;
    c_val_d  = c_val_q;
    c_last_d = c_last_q;
    c_src_d  = c_src_q;
    if (xfer) begin
      c_d      = p[sel_idx*DW +: DW];
      c_val_d  = 1'b1;
      c_last_d = sel_last;
      c_src_d  = sel_idx;
    end else if (c_val_q && c_rdy) begin
      c_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      lk_idx_q <= '0;
      c_q      <= '0;
      c_val_q  <= 1'b0;
      c_last_q <= 1'b0;
      c_src_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lk_idx_q <= lk_idx_d;
      c_q      <= c_d;
      c_val_q  <= c_val_d;
      c_last_q <= c_last_d;
      c_src_q  <= c_src_d;
    end
  end

  assign c      = c_q;
  assign c_val  = c_val_q;
  assign c_last = c_last_q;
  assign c_src  = c_src_q;

endmodule

// File: tb/tb_stdcore_vrr_arb.sv
// tb/tb_stdcore_vrr_arb.sv - randomized self-checking bench for stdcore_vrr_arb
module tb_stdcore_vrr_arb;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            arst;
  logic [N*DW-1:0] p;
  logic [N-1:0]    p_val;
  logic [N-1:0]    p_last;
  logic [N-1:0]    p_rdy;
  logic [DW-1:0]   c;
  logic            c_val;
  logic            c_last;
  logic [SW-1:0]   c_src;
  logic            c_rdy;

  always #5 clk = ~clk;

  stdcore_vrr_arb #(
    .DW (DW),
    .N  (N),
    .SW (SW)
  ) dut (
    .clk    (clk),
    .arst   (arst),
    .p      (p),
    .p_val  (p_val),
    .p_last (p_last),
    .p_rdy  (p_rdy),
    .c      (c),
    .c_val  (c_val),
    .c_last (c_last),
    .c_src  (c_src),
    .c_rdy  (c_rdy)
  );

  int checks = 0;
  int errors = 0;

  // Reference: who owns the grant, where the next search starts, what sits in the output slot.
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  bit            m_cval;
  logic [DW-1:0] m_c;
  bit            m_clast;
  int            m_csrc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cval   = 0;
    m_c      = '0;
    m_clast  = 0;
    m_csrc   = 0;
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks both sides.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
    int            g;
    bit            room;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] beat;
    p_val  = v;
    p_last = l;
    c_rdy  = rdy;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = DW'($urandom);
    #1;
    g = -1;
    if (m_locked) g = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    room    = !m_cval || rdy;
    exp_rdy = (room && g >= 0) ? N'(1 << g) : '0;
    check("p_rdy", 32'(p_rdy), 32'(exp_rdy));
    beat = (g >= 0) ? p[g*DW +: DW] : '0;
    @(posedge clk);
    if (room && g >= 0 && v[g]) begin
      m_cval  = 1;
      m_c     = beat;
      m_clast = l[g];
      m_csrc  = g;
      if (l[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % N;
      end else begin
        m_locked = 1;
        m_owner  = g;
      end
    end else if (m_cval && rdy) begin
      m_cval = 0;
    end
    @(negedge clk);
    check("c_val", 32'(c_val), 32'(m_cval));
    check("c", 32'(c), 32'(m_c));
    check("c_last", 32'(c_last), 32'(m_clast));
    check("c_src", 32'(c_src), 32'(m_csrc));
  endtask

  initial begin
    int vp[4] = '{90, 40, 100, 70};
    int lp[4] = '{30, 60, 100, 20};
    int rp[4] = '{100, 70, 100, 30};
    logic [N-1:0] v, l;
    logic         r;

    arst   = 1'b1;
    p      = '0;
    p_val  = '1;
    p_last = '0;
    c_rdy  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_c_val", 32'(c_val), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_c_src", 32'(c_src), 32'd0);
    check("rst_p_rdy", 32'(p_rdy), 32'd0);
    arst = 1'b0;

    step(4'b0100, 4'b0100, 1'b1);
    check("single_src", 32'(c_src), 32'd2);
    check("single_last", 32'(c_last), 32'd1);
    step(4'b1111, 4'b1111, 1'b1);
    check("after_single_src", 32'(c_src), 32'd3);

    step(4'b0100, 4'b0000, 1'b1);
    check("lock_src", 32'(c_src), 32'd2);
    p_val = 4'b1111;
    arst  = 1'b1;
    #1;
    check("arst_c_val", 32'(c_val), 32'd0);
    check("arst_p_rdy", 32'(p_rdy), 32'd0);
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    step(4'b0101, 4'b0101, 1'b1);
    check("post_rst_src", 32'(c_src), 32'd0);

    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 300; n++) begin
        for (int i = 0; i < N; i++) begin
          v[i] = ($urandom_range(99) < vp[ph]);
          l[i] = ($urandom_range(99) < lp[ph]);
        end
        r = ($urandom_range(99) < rp[ph]);
        step(v, l, r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
